// File: rtl/sig_mmio_ctrl_if.sv
// Store-path and signature-stream bundle for sig_mmio_ctrl.
// master: core store stage plus signature consumer; slave: the controller.
interface sig_mmio_ctrl_if;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        stall;
    logic        sig_valid;
    logic [31:0] sig_data;
    logic        sig_ready;
    logic        halt;
    logic        timeout;
    logic [15:0] sig_count;

    modport master (
        output wr, addr, data_wr, sig_ready,
        input  stall, sig_valid, sig_data, halt, timeout, sig_count
    );

    modport slave (
        input  wr, addr, data_wr, sig_ready,
        output stall, sig_valid, sig_data, halt, timeout, sig_count
    );
endinterface

// File: rtl/sig_mmio_ctrl.sv
// Signature capture and halt controller on the data-memory store path.
// Stores to SIG_ADDR are queued and drained over ready/valid; a store to
// HALT_ADDR stalls the core, drains the queue, then raises sticky halt.
// Optional feature macro: SIG_TIMEOUT_EN (cycle-limit shutdown in RUN).
module sig_mmio_ctrl #(
    parameter logic [31:0] SIG_ADDR   = 32'h0000_0F00,
    parameter logic [31:0] HALT_ADDR  = 32'hCAFE_BEEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 500000
) (
    input logic            clk,
    input logic            rst,
    sig_mmio_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t      state;
    logic        halt_q;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_next;
    logic [15:0] count_q;
    logic        sig_st;
    logic        halt_st;
    logic        empty;
    logic        full;
    logic        valid;
    logic        push;
    logic        pop;
    logic        drained;

    assign sig_st  = ~bus.wr & (bus.addr == SIG_ADDR);
    assign halt_st = ~bus.wr & (bus.addr == HALT_ADDR);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid   = ~empty & (state != HALTED);
    assign push    = (state == RUN) & sig_st & ~full;
    assign pop     = valid & bus.sig_ready;
    assign rd_next = rd_ptr + (AW+1)'(1);
    // No pushes happen outside RUN, so popping the entry just below wr_ptr empties the queue.
    assign drained = empty | (pop & (rd_next == wr_ptr));

    assign bus.stall     = (state == RUN) ? (sig_st & full) : 1'b1;
    assign bus.sig_valid = valid;
    assign bus.sig_data  = valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign bus.halt      = halt_q;
    assign bus.sig_count = count_q;

`ifdef SIG_TIMEOUT_EN
    logic [31:0] cycle_cnt;
    logic        timeout_q;
    logic        timeout_hit;

    assign timeout_hit = (cycle_cnt == 32'(TIMEOUT - 1));
    assign bus.timeout = timeout_q;

    // Free-running cycle count while the core is running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign bus.timeout    = 1'b0;
`endif

    // Shutdown sequencing: RUN until halt store (or timeout), DRAIN until empty, then HALTED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            halt_q <= 1'b0;
`ifdef SIG_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (halt_st) begin
                        state <= DRAIN;
                    end
`ifdef SIG_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state     <= DRAIN;
                        timeout_q <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (drained) begin
                        state  <= HALTED;
                        halt_q <= 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Queue pointers and saturating count of accepted signature words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
                if (count_q != '1) begin
                    count_q <= count_q + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
        end
    end

    // Queue storage; contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.data_wr;
        end
    end
endmodule

// File: tb/tb_sig_mmio_ctrl.sv
// Self-checking bench for sig_mmio_ctrl: per-cycle vector table plus
// hand-written shutdown/reset sequences, with a scoreboard on the signature port.
// Optional feature macro: SIG_TIMEOUT_EN (enables the timeout sequences).
module tb_sig_mmio_ctrl;
    localparam logic [31:0] SIG  = 32'h0000_0F00;
    localparam logic [31:0] HLT  = 32'hCAFE_BEEF;

    typedef struct {
        logic        do_reset;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ready;
        logic        exp_stall;
        logic        exp_valid;
        logic [15:0] exp_count;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];
    logic [31:0] exp_q[$];

    sig_mmio_ctrl_if bus();

    sig_mmio_ctrl #(
        .SIG_ADDR  (SIG),
        .HALT_ADDR (HLT),
        .FIFO_DEPTH(8),
        .TIMEOUT   (100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%h req=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every word popped by the consumer must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && bus.sig_valid && bus.sig_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: act=%h req=none", bus.sig_data);
            end else begin
                chk("sb_data", bus.sig_data, exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        bus.wr = 1'b1;
        bus.addr = '0;
        bus.data_wr = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        bus.sig_ready = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        bus.wr = w;
        bus.addr = a;
        bus.data_wr = d;
        bus.sig_ready = r;
    endtask

    task automatic store_sig(input logic [31:0] d, input logic r);
        step(1'b0, SIG, d, r);
        exp_q.push_back(d);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            step(1'b1, '0, '0, 1'b1);
        end
        @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle_inputs();
        bus.sig_ready = 1'b0;

        // Table: A1..A3 streaming, then 9 stores into a depth-8 queue with backpressure.
        vecs.push_back('{1'b1, 1'b0, SIG, 32'hA1, 1'b1, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b0, SIG, 32'hA2, 1'b1, 1'b0, 1'b1, 16'd1});
        vecs.push_back('{1'b0, 1'b0, SIG, 32'hA3, 1'b1, 1'b0, 1'b1, 16'd2});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 16'd3});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd3});
        for (int unsigned k = 0; k < 8; k++) begin
            vecs.push_back('{(k == 0), 1'b0, SIG, 32'(k + 1), 1'b0, 1'b0, (k != 0), 16'(k)});
        end
        vecs.push_back('{1'b0, 1'b0, SIG, 32'd9, 1'b0, 1'b1, 1'b1, 16'd8});
        vecs.push_back('{1'b0, 1'b0, SIG, 32'd9, 1'b0, 1'b1, 1'b1, 16'd8});
        vecs.push_back('{1'b0, 1'b0, SIG, 32'd9, 1'b1, 1'b1, 1'b1, 16'd8});
        vecs.push_back('{1'b0, 1'b0, SIG, 32'd9, 1'b1, 1'b0, 1'b1, 16'd8});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 16'd9});

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_valid", 32'(bus.sig_valid), 32'd0);
        chk("rst_data", bus.sig_data, 32'd0);
        chk("rst_halt", 32'(bus.halt), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_count", 32'(bus.sig_count), 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) begin
                wait_drain("tbl_drain_pre");
                apply_reset();
            end
            step(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].ready);
            if (!vecs[i].wr && vecs[i].addr == SIG && !vecs[i].exp_stall) begin
                exp_q.push_back(vecs[i].data);
            end
            @(negedge clk);
            chk($sformatf("tbl_stall[%0d]", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
            chk($sformatf("tbl_valid[%0d]", i), 32'(bus.sig_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("tbl_count[%0d]", i), 32'(bus.sig_count), 32'(vecs[i].exp_count));
        end
        wait_drain("tbl_drain");

        // Halt with three queued words: drain only once the consumer is ready.
        apply_reset();
        store_sig(32'h31, 1'b0);
        store_sig(32'h32, 1'b0);
        store_sig(32'h33, 1'b0);
        step(1'b0, HLT, 32'h0, 1'b0);
        @(negedge clk);
        chk("h3_stall_run", 32'(bus.stall), 32'd0);
        step(1'b1, '0, '0, 1'b0);
        @(negedge clk);
        chk("h3_stall_drain", 32'(bus.stall), 32'd1);
        chk("h3_halt_drain", 32'(bus.halt), 32'd0);
        step(1'b1, '0, '0, 1'b0);
        @(negedge clk);
        chk("h3_valid_hold", 32'(bus.sig_valid), 32'd1);
        chk("h3_halt_hold", 32'(bus.halt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, '0, '0, 1'b1);
            @(negedge clk);
            chk($sformatf("h3_halt_pop%0d", i), 32'(bus.halt), 32'd0);
        end
        step(1'b1, '0, '0, 1'b1);
        @(negedge clk);
        chk("h3_halt", 32'(bus.halt), 32'd1);
        chk("h3_timeout", 32'(bus.timeout), 32'd0);
        chk("h3_valid", 32'(bus.sig_valid), 32'd0);
        chk("h3_stall", 32'(bus.stall), 32'd1);
        chk("h3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Halt with an empty queue: halt two cycles later; later stores are ignored.
        apply_reset();
        step(1'b0, HLT, 32'h0, 1'b1);
        @(negedge clk);
        chk("h0_halt_n", 32'(bus.halt), 32'd0);
        step(1'b1, '0, '0, 1'b1);
        @(negedge clk);
        chk("h0_halt_n1", 32'(bus.halt), 32'd0);
        chk("h0_stall_n1", 32'(bus.stall), 32'd1);
        step(1'b1, '0, '0, 1'b1);
        @(negedge clk);
        chk("h0_halt_n2", 32'(bus.halt), 32'd1);
        step(1'b0, SIG, 32'h77, 1'b1);
        @(negedge clk);
        chk("h0_stall_store", 32'(bus.stall), 32'd1);
        step(1'b1, '0, '0, 1'b1);
        @(negedge clk);
        chk("h0_count", 32'(bus.sig_count), 32'd0);
        chk("h0_valid", 32'(bus.sig_valid), 32'd0);
        chk("h0_halt_sticky", 32'(bus.halt), 32'd1);

`ifdef SIG_TIMEOUT_EN
        // Timeout after 100 RUN cycles.
        apply_reset();
        for (int i = 1; i < 100; i++) begin
            step(1'b1, '0, '0, 1'b1);
        end
        @(negedge clk);
        chk("to_run_c99", 32'(bus.stall), 32'd0);
        step(1'b1, '0, '0, 1'b1);
        @(negedge clk);
        chk("to_drain_c100", 32'(bus.stall), 32'd1);
        chk("to_halt_c100", 32'(bus.halt), 32'd0);
        step(1'b1, '0, '0, 1'b1);
        @(negedge clk);
        chk("to_halt", 32'(bus.halt), 32'd1);
        chk("to_timeout", 32'(bus.timeout), 32'd1);

        // Halt store in cycle 99 beats the timeout.
        apply_reset();
        for (int i = 1; i < 99; i++) begin
            step(1'b1, '0, '0, 1'b1);
        end
        step(1'b0, HLT, 32'h0, 1'b1);
        step(1'b1, '0, '0, 1'b1);
        step(1'b1, '0, '0, 1'b1);
        @(negedge clk);
        chk("to99_halt", 32'(bus.halt), 32'd1);
        chk("to99_timeout", 32'(bus.timeout), 32'd0);
`else
        // Without the timeout feature the block keeps running indefinitely.
        apply_reset();
        for (int i = 0; i < 120; i++) begin
            step(1'b1, '0, '0, 1'b1);
        end
        @(negedge clk);
        chk("nto_stall", 32'(bus.stall), 32'd0);
        chk("nto_halt", 32'(bus.halt), 32'd0);
        chk("nto_timeout", 32'(bus.timeout), 32'd0);
`endif

        // Asynchronous reset while draining four words, then normal operation.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            store_sig(32'h61 + 32'(i), 1'b0);
        end
        step(1'b0, HLT, 32'h0, 1'b0);
        step(1'b1, '0, '0, 1'b0);
        @(negedge clk);
        chk("ar_stall_drain", 32'(bus.stall), 32'd1);
        chk("ar_count_pre", 32'(bus.sig_count), 32'd4);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("ar_stall", 32'(bus.stall), 32'd0);
        chk("ar_valid", 32'(bus.sig_valid), 32'd0);
        chk("ar_data", bus.sig_data, 32'd0);
        chk("ar_halt", 32'(bus.halt), 32'd0);
        chk("ar_timeout", 32'(bus.timeout), 32'd0);
        chk("ar_count", 32'(bus.sig_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        store_sig(32'h65, 1'b1);
        @(negedge clk);
        chk("ar_post_stall", 32'(bus.stall), 32'd0);
        step(1'b1, '0, '0, 1'b1);
        @(negedge clk);
        chk("ar_post_count", 32'(bus.sig_count), 32'd1);
        chk("ar_post_valid", 32'(bus.sig_valid), 32'd1);
        wait_drain("ar_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
